// File: rtl/multi_input_logic_reducer_pkg.sv
// Shared definitions for the multi-input logic reducer: function-select codes,
// FSM state encodings and the per-beat fold used by the accumulator.
package multi_input_logic_reducer_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Fold one reduced beat into the running result; 1x selects XOR.
  function automatic logic combine(input logic a, input logic b, input logic [1:0] op);
    logic r;
    r = a ^ b;
    if (op == 2'b00) r = a & b;
    else if (op == 2'b01) r = a | b;
    return r;
  endfunction

endpackage

// File: rtl/multi_input_logic_reducer_reduce_word.sv
// Combinational WIDTH-bit reduction (AND/OR/XOR) selected by op[1:0].
// The NAND/NOR/XNOR inversion is deliberately not applied here.
module reduce_word #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  output logic             y
);

  always_comb begin
    y = ^data;
    if (op == 2'b00) y = &data;
    else if (op == 2'b01) y = |data;
  end

endmodule

// File: rtl/multi_input_logic_reducer.sv
// Registered multi-beat logic reducer with valid/ready on both sides.
// Folds up to BEATS beats of WIDTH bits into one result, inverted once at output.
module multi_input_logic_reducer
  import multi_input_logic_reducer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BEATS = 1,
  parameter int CW    = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CW-1:0]    out_count
);

  state_t          state_reg;
  logic [2:0]      op_reg;
  logic            acc_reg;
  logic [CW-1:0]   count_reg;
  logic            out_y_reg;
  logic [CW-1:0]   out_count_reg;

  logic            accept;
  logic            beat_y;
  logic [2:0]      op_next;
  logic            acc_next;
  logic [CW-1:0]   count_next;
  logic            frame_end;

  assign accept = in_valid && in_ready;

  // The op is taken from the bus only on the first beat of a frame.
  always_comb begin
    op_next    = op_reg;
    acc_next   = combine(acc_reg, beat_y, op_reg[1:0]);
    count_next = count_reg + CW'(1);
    if (state_reg == ST_IDLE) begin
      op_next    = in_op;
      acc_next   = beat_y;
      count_next = CW'(1);
    end
    frame_end = in_last || (count_next == CW'(BEATS));
  end

  reduce_word #(.WIDTH(WIDTH)) u_reduce (
    .data (in_data),
    .op   (op_next[1:0]),
    .y    (beat_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_AND;
      acc_reg       <= 1'b0;
      count_reg     <= '0;
      out_y_reg     <= 1'b0;
      out_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            if (frame_end) begin
              state_reg     <= ST_HOLD;
              out_y_reg     <= acc_next ^ op_next[2];
              out_count_reg <= count_next;
            end else begin
              state_reg <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg != ST_HOLD);
  assign out_valid = (state_reg == ST_HOLD);
  assign out_y     = out_y_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_multi_input_logic_reducer.sv
// Scoreboard bench for multi_input_logic_reducer (WIDTH=4, BEATS=4); frames
// shorter than BEATS are cut with in_last, results are checked by a monitor.
module tb_multi_input_logic_reducer;

  localparam int WIDTH = 4;
  localparam int BEATS = 4;
  localparam int CW    = $clog2(BEATS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic [CW-1:0]    out_count;

  typedef struct packed {
    logic          y;
    logic [CW-1:0] count;
  } result_t;

  result_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int frame_no     = 0;

  multi_input_logic_reducer #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("out_y", int'(out_y), int'(e.y));
        check("out_count", int'(out_count), int'(e.count));
        $display("[TB] result %0d: y=%0d count=%0d (exp y=%0d count=%0d)",
                 frame_no, out_y, out_count, e.y, e.count);
        frame_no++;
      end
    end
  end

  // Offer one beat (called at posedge+1) and return at posedge+1 after acceptance.
  task automatic send(input logic [3:0] d, input logic [2:0] op, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_op    = 3'b000;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input logic y, input int count);
    result_t r;
    r.y     = y;
    r.count = CW'(count);
    exp_q.push_back(r);
  endtask

  // Called right after the final beat: result one cycle later, handshake, back to IDLE.
  task automatic finish_frame();
    @(negedge clk);
    check("latency_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 3'b000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_y", int'(out_y), 0);
    check("reset_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;

    // Single-beat AND frames.
    send(4'b1111, 3'b000, 1'b1); expect_result(1'b1, 1); finish_frame();
    send(4'b1011, 3'b000, 1'b1); expect_result(1'b0, 1); finish_frame();

    // Three-beat XOR and XNOR (popcount 6).
    send(4'b0001, 3'b010, 1'b0); send(4'b0011, 3'b010, 1'b0);
    send(4'b0111, 3'b010, 1'b1); expect_result(1'b0, 3); finish_frame();
    send(4'b0001, 3'b110, 1'b0); send(4'b0011, 3'b110, 1'b0);
    send(4'b0111, 3'b110, 1'b1); expect_result(1'b1, 3); finish_frame();

    // Full BEATS frame with no in_last: XOR of 1,0,1,1 -> 1.
    send(4'b0001, 3'b010, 1'b0); send(4'b0011, 3'b010, 1'b0);
    send(4'b0111, 3'b010, 1'b0); send(4'b0001, 3'b010, 1'b0);
    expect_result(1'b1, 4); finish_frame();

    // in_last on the BEATS-th beat terminates once; the next beat starts a new frame.
    send(4'b0000, 3'b001, 1'b0); send(4'b0000, 3'b001, 1'b0);
    send(4'b0000, 3'b001, 1'b0); send(4'b0000, 3'b001, 1'b1);
    expect_result(1'b0, 4); finish_frame();
    send(4'b1111, 3'b000, 1'b1); expect_result(1'b1, 1); finish_frame();

    // op 011 aliases XOR, op 111 aliases XNOR.
    send(4'b0011, 3'b011, 1'b1); expect_result(1'b0, 1); finish_frame();
    send(4'b0011, 3'b111, 1'b1); expect_result(1'b1, 1); finish_frame();

    // Early-terminated NOR frame held under backpressure with a beat still offered.
    out_ready = 1'b0;
    send(4'b0000, 3'b101, 1'b0);
    send(4'b0000, 3'b101, 1'b1);
    expect_result(1'b1, 2);
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_op    = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_y", int'(out_y), 1);
      check("bp_out_count", int'(out_count), 2);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // in_op change mid-frame is ignored: OR of 0000,0100 -> 1 (AND would give 0).
    send(4'b0000, 3'b001, 1'b0); send(4'b0100, 3'b000, 1'b1);
    expect_result(1'b1, 2); finish_frame();

    // Reset in ACCUM discards the partial frame and clears the outputs.
    send(4'b0000, 3'b000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_out_y", int'(out_y), 0);
    check("rst_mid_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;
    send(4'b1111, 3'b000, 1'b0); send(4'b1111, 3'b000, 1'b0);
    send(4'b1111, 3'b000, 1'b1); expect_result(1'b1, 3); finish_frame();

    // Drain check: every expected result must have been seen.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_input_logic_reducer.md
Name: multi_input_logic_reducer

Overview:
Parametrised, registered successor to the fixed 4-input AND gate. Reduces WIDTH input bits per beat with a selectable logic function (AND/OR/XOR and their inversions). Accumulates the result across up to BEATS consecutive beats, so one result can cover WIDTH*BEATS inputs. Valid/ready handshakes on both input and output; it sits between lab input sources (switches, shift registers) and a display or downstream logic stage.

Parameters:
WIDTH, 4, input bits reduced per beat (>=1)
BEATS, 1, maximum beats folded into one result (>=1)
CW, $clog2(BEATS+1), width of the beat-count output (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat offered
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  bits to reduce
in_op  input  3  function select, sampled on first beat of a frame
in_last  input  1  early frame terminator, sampled with each accepted beat
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_y  output  1  reduced result
out_count  output  CW  number of beats folded into out_y (1..BEATS)

Behaviour:
- One clock; rst is synchronous and active-high. Reset: state IDLE, in_ready=1, out_valid=0, out_y=0, out_count=0, accumulator=0, beat counter=0.
- Beat accepted when in_valid & in_ready.
- in_op decode: op[1:0] 00=AND, 01=OR, 1x=XOR (11 aliases 10); op[2]=1 inverts the final result (NAND/NOR/XNOR). The inversion is applied once at output, never per beat.
- States:
  - IDLE: in_ready=1. On an accepted beat: latch op, acc=reduce(in_data), count=1. If in_last=1 or BEATS=1, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready=1. On an accepted beat: acc=acc (op) reduce(in_data), count+=1. If in_last=1 or count reaches BEATS, go to HOLD. in_op is ignored in ACCUM. Idle cycles (in_valid=0) hold state indefinitely.
  - HOLD: in_ready=0, out_valid=1, out_y=acc^op[2], out_count=count. out_y and out_count stay stable until out_valid & out_ready; then go to IDLE.
- Latency: out_valid rises the cycle after the final beat is accepted. On a handshake in cycle t, out_valid=0 and in_ready=1 from cycle t+1.
- No input is accepted in the handshake cycle. Minimum period is BEATS+1 cycles per full frame, or 2 cycles when BEATS=1.
- out_y and out_count hold their last values after the handshake until the next HOLD; they are qualified only by out_valid.
- in_last with the BEATS-th beat: a single termination, no extra beat.
- rst mid-frame or in HOLD discards the partial or pending result. All outputs return to their reset values on the next edge.
- WIDTH=1: reduce(x)=x. The BEATS=WIDTH=1 case must elaborate.
- in_data and in_op need not be stable except in the accept cycle.

Decomposition:
- Shared include/package: op code constants (OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NAND=3'b100, OP_NOR=3'b101, OP_XNOR=3'b110) and state encodings (IDLE, ACCUM, HOLD).
- One sub-module: reduce_word, a combinational WIDTH-bit reduction selected by op[1:0], without inversion. It is instantiated once; the FSM, counter and accumulator live in the top module.

Test Plan:
1. Defaults (WIDTH=4, BEATS=1), op=000, in_data=4'b1111 then 4'b1011 with out_ready=1 -> out_y=1 then 0, out_count=1, each one cycle after accept.
2. WIDTH=4, BEATS=3, op=010 (XOR), beats 4'b0001, 4'b0011, 4'b0111 -> out_y=0 (popcount 6), out_count=3. Repeat with op=110 (XNOR) -> out_y=1.
3. BEATS=4, op=101 (NOR), beats 4'b0000 then 4'b0000 with in_last=1 -> early termination, out_y=1, out_count=2, no third beat consumed.
4. Backpressure: result pending, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 throughout, out_y/out_count stable. out_ready=1 -> in_ready=1 next cycle.
5. in_op changed 001→000 mid-frame (BEATS=2, beats 4'b0000, 4'b0100) -> the OR is kept, out_y=1.
6. rst asserted in ACCUM after 1 of 3 beats -> next cycle out_valid=0 and in_ready=1. A fresh 3-beat AND frame of 4'b1111 gives out_y=1, out_count=3, unaffected by the discarded beat.
